// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V main control FSM sequencing fetch, decode, execute, memory and writeback.
module mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
                         MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  logic [3:0] nxt;
  logic       pcw, irw, mw, rw, ill;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= nxt;
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE:   nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
                      op == OP_R ? EXECR : op == OP_I ? EXECI :
                      op == OP_BEQ ? BEQ : op == OP_JAL ? JAL : FETCH;
      MEMADR:   nxt = op == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
      EXECR:    nxt = ALUWB;
      EXECI:    nxt = ALUWB;
      JAL:      nxt = ALUWB;
      default:  nxt = FETCH;
    endcase
  end
  always_comb begin
    pcw = 1'b0;
    irw = 1'b0;
    mw = 1'b0;
    rw = 1'b0;
    ill = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    ImmSrc = op == OP_SW ? 2'b01 : op == OP_BEQ ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
    case (state)
      FETCH: begin
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        irw = mem_ready;
        pcw = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ill = !(op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BEQ || op == OP_JAL);
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        rw = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mw = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp = 2'b10;
      end
      ALUWB: rw = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp = 2'b01;
        pcw = zero;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw = 1'b1;
      end
      default: ;
    endcase
  end
  // write strobes are gated by reset directly so nothing commits once rst_n falls
  assign PCWrite = pcw & rst_n;
  assign IRWrite = irw & rst_n;
  assign MemWrite = mw & rst_n;
  assign RegWrite = rw & rst_n;
  assign illegal = ill & rst_n;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: random instruction stream checked against an instruction-level sequence model.
module tb_mc_controller;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [6:0] op = 7'b0100011;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0] state;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  mc_controller dut (.clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .illegal(illegal), .state(state));
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] outs();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal};
  endfunction
  function automatic bit legal(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 || o == 7'b0010011 ||
           o == 7'b1100011 || o == 7'b1101111;
  endfunction
  // expected control word for a state, from the per-state output table
  function automatic logic [15:0] ex(input int s, input logic mr, input logic z, input logic [6:0] o);
    logic pw, as, mw, iw, rw, il;
    logic [1:0] rs, sa, sb, ao, im;
    {pw, as, mw, iw, rw, il} = '0;
    {rs, sa, sb, ao} = '0;
    im = o == 7'b0100011 ? 2'd1 : o == 7'b1100011 ? 2'd2 : o == 7'b1101111 ? 2'd3 : 2'd0;
    case (s)
      0: begin sb = 2; rs = 2; iw = mr; pw = mr; end
      1: begin sa = 1; sb = 1; il = !legal(o); end
      2: begin sa = 2; sb = 1; end
      3: as = 1;
      4: begin rs = 1; rw = 1; end
      5: begin as = 1; mw = 1; end
      6: begin sa = 2; ao = 2; end
      7: begin sa = 2; sb = 1; ao = 2; end
      8: rw = 1;
      9: begin sa = 2; ao = 1; pw = z; end
      10: begin sa = 1; sb = 2; pw = 1; end
      default: ;
    endcase
    return {pw, as, mw, iw, rw, rs, sa, sb, ao, im, il};
  endfunction
  // builds the whole cycle-by-cycle state trace of one instruction, then replays it
  task automatic run_instr(input logic [6:0] o, input int k1, input int k2);
    int sq[$];
    logic mq[$];
    logic z;
    op = o;
    for (int i = 0; i <= k1; i++) begin sq.push_back(0); mq.push_back(i == k1); end
    sq.push_back(1); mq.push_back(1'($urandom));
    if (o == 7'b0000011 || o == 7'b0100011) begin
      sq.push_back(2); mq.push_back(1'($urandom));
      for (int i = 0; i <= k2; i++) begin sq.push_back(o == 7'b0000011 ? 3 : 5); mq.push_back(i == k2); end
      if (o == 7'b0000011) begin sq.push_back(4); mq.push_back(1'($urandom)); end
    end else if (o == 7'b0110011 || o == 7'b0010011 || o == 7'b1101111) begin
      sq.push_back(o == 7'b0110011 ? 6 : o == 7'b0010011 ? 7 : 10); mq.push_back(1'($urandom));
      sq.push_back(8); mq.push_back(1'($urandom));
    end else if (o == 7'b1100011) begin
      sq.push_back(9); mq.push_back(1'($urandom));
    end
    foreach (sq[i]) begin
      z = 1'($urandom);
      mem_ready = mq[i];
      zero = z;
      #1;
      check($sformatf("state op=%b c%0d", o, i), {12'd0, state}, 16'(sq[i]));
      check($sformatf("outs op=%b s%0d", o, sq[i]), outs(), ex(sq[i], mq[i], z, o));
      @(negedge clk);
    end
  endtask
  logic [6:0] ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1111111};
  initial begin
    int w;
    mem_ready = 1'b1;
    #3;
    check("reset state", {12'd0, state}, 16'd0);
    check("reset outs", outs(), ex(0, 1'b0, 1'b0, op));
    @(negedge clk);
    rst_n = 1'b1;
    w = 0;
    while (state != 4'd5 && w < 10) begin @(negedge clk); w++; end
    check("reach MEMWRITE", {12'd0, state}, 16'd5);
    mem_ready = 1'b0;
    #1;
    check("memwrite wait", {15'd0, MemWrite}, 16'd1);
    #2;
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async rst state", {12'd0, state}, 16'd0);
    check("async rst outs", outs(), ex(0, 1'b0, 1'b0, op));
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("hold fetch", {12'd0, state}, 16'd0);
      check("hold outs", outs(), ex(0, 1'b0, zero, op));
    end
    @(negedge clk);
    for (int i = 0; i < 7; i++) run_instr(ops[i], 0, 0);
    run_instr(7'b0100011, 0, 3);
    for (int i = 0; i < 80; i++)
      run_instr($urandom_range(0, 4) == 0 ? 7'($urandom) : ops[$urandom_range(0, 6)],
                $urandom_range(0, 3), $urandom_range(0, 3));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
